carrier_wipeoff_acc: RTL and testbench
======================================

Name: carrier_wipeoff_acc

Overview:
Parametrised carrier-wipeoff and coherent-accumulate unit for the acquire engine. Each sign/magnitude complex IF sample is multiplied by an internally generated 4-bit sign/magnitude carrier, e^{-jθ}, taken from a 32-point phase NCO. The products are accumulated over a programmable number of samples and then dumped. The unit sits between the sample buffer and the correlator/FFT stage.

Parameters:
SMP_MAG_BITS, 1, sample magnitude field width; magnitude value = 2*m+1, so the default gives 1 or 3
PHASE_WIDTH, 32, NCO phase accumulator and frequency word width
ACC_WIDTH, 16, signed width of each I/Q accumulator
CNT_WIDTH, 16, width of dump_len and the sample counter

Ports:
clk  in  1  clock; all logic rising-edge
rst  in  1  asynchronous active-high reset
enable  in  1  block enable; low = synchronous flush
freq_word  in  PHASE_WIDTH  phase increment per accepted sample (unsigned, wraps)
phase_init  in  PHASE_WIDTH  value loaded into the NCO
phase_load  in  1  one-cycle pulse; loads phase_init
dump_len  in  CNT_WIDTH  samples per dump; 0 is treated as 1
sample_valid  in  1  sample_sm is valid this cycle
sample_sm  in  2*(SMP_MAG_BITS+1)  {i_sign, i_mag, q_sign, q_mag}; sign 1 = negative
acc_i  out  ACC_WIDTH  dumped I sum, two's complement, held between dumps
acc_q  out  ACC_WIDTH  dumped Q sum, held between dumps
dump_valid  out  1  one-cycle pulse when acc_i/acc_q update
carrier_phase  out  PHASE_WIDTH  current NCO phase

Behaviour:
- Reset: phase=0, sample counter=0, internal accumulators=0, pipeline valids=0; acc_i=acc_q=0, dump_valid=0.
- NCO, stage 0:
  - Each accepted sample (sample_valid && enable) uses the current phase, then phase <= phase+freq_word.
  - phase_load has priority: phase <= phase_init. A sample accepted in the same cycle uses the OLD phase.
- Carrier LUT:
  - q = phase[MSB:MSB-1]; k = phase[MSB-2:MSB-4].
  - T[0..7] = 7,7,6,5,4,3,2,1.
  - Even q: cos_mag=T[k], sin_mag=T[7-k]. Odd q: cos_mag=T[7-k], sin_mag=T[k].
  - cos_sign=1 for q=1,2; sin_sign=1 for q=2,3.
- Multiply, stage 1 (registered):
  - I = si*cos + sq*sin; Q = sq*cos - si*sin, where si and sq are the signed sample values.
  - Products use signed width PW = SMP_MAG_BITS+6, sized so the worst case cannot overflow.
  - Exactly 1 cycle from acceptance to registered product.
- Accumulate, stage 2:
  - Add the sign-extended product into the internal accumulators; count accepted samples.
  - When the count reaches max(dump_len,1):
    - acc_i/acc_q <= accumulator plus the current product.
    - dump_valid=1 for one cycle.
    - Accumulators and counter restart from 0 on the following sample (no sample lost).
  - Latency: the last sample accepted at cycle t gives dump_valid at t+2.
- Back-to-back samples every cycle are supported with no stall. dump_len is sampled when the counter is 0.
- Accumulator overflow wraps in two's complement (see the optional feature).
- enable low:
  - New samples are ignored.
  - Pipeline valids, counter and internal accumulators clear on the next edge.
  - No dump is produced for the partial block.
  - phase holds; acc_i/acc_q hold.
- Asynchronous reset mid-block discards all in-flight data.

Optional Feature:
ACC_SATURATE_EN:
- Defined: the internal accumulators saturate at +(2^(ACC_WIDTH-1)-1) and -2^(ACC_WIDTH-1), and stay clamped until the dump.
- Undefined: plain two's-complement wrap.

Test Plan:
- Basic dump: rst, phase_load 0, freq_word 0, dump_len 4, four samples I=+3/Q=+1 (sample_sm=4'b0100) -> one dump_valid at 2 cycles after the 4th sample; acc_i=88, acc_q=16.
- Quadrant 1: phase_init 0x40000000, freq_word 0, dump_len 1, same sample -> acc_i=4, acc_q=-22.
- Phase advance: phase_load 0, freq_word 0x08000000, 8 consecutive samples -> carrier_phase=0x40000000 after the 8th; dump contents match the per-sample LUT sum.
- Back-to-back dumps: dump_len 2, 6 samples on consecutive cycles -> 3 dump_valid pulses 2 cycles apart, with no gap and no lost sample.
- Flush: dump_len 4, drop enable after 2 samples, re-enable, 4 samples -> only the second block is dumped; acc values equal those of 4 samples.
- Saturation: ACC_WIDTH 8, dump_len 8, sample I=+3/Q=+1 at phase 0 -> with ACC_SATURATE_EN acc_i=127; without it acc_i=-80 (176 wrapped).

Source files
------------

// File: rtl/carrier_wipeoff_acc.sv
// carrier_wipeoff_acc: 32-point NCO carrier wipeoff with coherent I/Q accumulate-and-dump.
// Define ACC_SATURATE_EN for saturating accumulators; default build wraps.
module carrier_wipeoff_acc #(
  parameter int SMP_MAG_BITS = 1,
  parameter int PHASE_WIDTH = 32,
  parameter int ACC_WIDTH = 16,
  parameter int CNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          enable,
  input  logic [PHASE_WIDTH-1:0]        freq_word,
  input  logic [PHASE_WIDTH-1:0]        phase_init,
  input  logic                          phase_load,
  input  logic [CNT_WIDTH-1:0]          dump_len,
  input  logic                          sample_valid,
  input  logic [2*(SMP_MAG_BITS+1)-1:0] sample_sm,
  output logic signed [ACC_WIDTH-1:0]   acc_i,
  output logic signed [ACC_WIDTH-1:0]   acc_q,
  output logic                          dump_valid,
  output logic [PHASE_WIDTH-1:0]        carrier_phase
);
  localparam int PW = SMP_MAG_BITS + 6;
  localparam int SW = SMP_MAG_BITS + 1;
  logic [PHASE_WIDTH-1:0] phase;
  logic accept, prod_v, last;
  logic [1:0] quad;
  logic [2:0] k, kn, t_k, t_kn, cos_mag, sin_mag;
  logic cos_neg, sin_neg;
  logic signed [PW-1:0] si_m, sq_m, si, sq, cv_m, sv_m, cv, sv;
  logic signed [PW-1:0] prod_i_d, prod_q_d, prod_i, prod_q;
  logic [CNT_WIDTH-1:0] cnt, len_r, len_eff;
  logic signed [ACC_WIDTH-1:0] acc_i_r, acc_q_r, sum_i, sum_q;
  assign accept = sample_valid && enable;
  assign carrier_phase = phase;
  // Quarter-wave table T[k] = 7,7,6,5,4,3,2,1 is 8-k modulo 8, except k=0.
  always_comb begin
    quad = phase[PHASE_WIDTH-1 -: 2];
    k = phase[PHASE_WIDTH-3 -: 3];
    kn = ~k;
    t_k = (k == 3'd0) ? 3'd7 : 3'd0 - k;
    t_kn = (kn == 3'd0) ? 3'd7 : 3'd0 - kn;
    cos_mag = quad[0] ? t_kn : t_k;
    sin_mag = quad[0] ? t_k : t_kn;
    cos_neg = quad[1] ^ quad[0];
    sin_neg = quad[1];
    si_m = {5'b0, sample_sm[2*SW-2 -: SMP_MAG_BITS], 1'b1};
    sq_m = {5'b0, sample_sm[SW-2 -: SMP_MAG_BITS], 1'b1};
    si = sample_sm[2*SW-1] ? -si_m : si_m;
    sq = sample_sm[SW-1] ? -sq_m : sq_m;
    cv_m = {{(PW-3){1'b0}}, cos_mag};
    sv_m = {{(PW-3){1'b0}}, sin_mag};
    cv = cos_neg ? -cv_m : cv_m;
    sv = sin_neg ? -sv_m : sv_m;
    prod_i_d = si * cv + sq * sv;
    prod_q_d = sq * cv - si * sv;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      phase <= '0;
      prod_v <= 1'b0;
      prod_i <= '0;
      prod_q <= '0;
    end else begin
      phase <= phase_load ? phase_init : accept ? phase + freq_word : phase;
      prod_v <= accept;
      if (accept) begin
        prod_i <= prod_i_d;
        prod_q <= prod_q_d;
      end
    end
  // Block length is latched from dump_len at the first sample of each block.
  assign len_eff = (cnt != '0) ? len_r : (dump_len == '0) ? CNT_WIDTH'(1) : dump_len;
  assign last = (cnt + CNT_WIDTH'(1)) == len_eff;
`ifdef ACC_SATURATE_EN
  logic signed [ACC_WIDTH:0] sw_i, sw_q;
  always_comb begin
    sw_i = (ACC_WIDTH+1)'(acc_i_r) + (ACC_WIDTH+1)'(prod_i);
    sw_q = (ACC_WIDTH+1)'(acc_q_r) + (ACC_WIDTH+1)'(prod_q);
    sum_i = (sw_i[ACC_WIDTH] != sw_i[ACC_WIDTH-1]) ? {sw_i[ACC_WIDTH], {(ACC_WIDTH-1){~sw_i[ACC_WIDTH]}}} : sw_i[ACC_WIDTH-1:0];
    sum_q = (sw_q[ACC_WIDTH] != sw_q[ACC_WIDTH-1]) ? {sw_q[ACC_WIDTH], {(ACC_WIDTH-1){~sw_q[ACC_WIDTH]}}} : sw_q[ACC_WIDTH-1:0];
  end
`else
  always_comb begin
    sum_i = acc_i_r + ACC_WIDTH'(prod_i);
    sum_q = acc_q_r + ACC_WIDTH'(prod_q);
  end
`endif
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      cnt <= '0;
      len_r <= '0;
      acc_i_r <= '0;
      acc_q_r <= '0;
      acc_i <= '0;
      acc_q <= '0;
      dump_valid <= 1'b0;
    end else if (!enable) begin
      cnt <= '0;
      acc_i_r <= '0;
      acc_q_r <= '0;
      dump_valid <= 1'b0;
    end else begin
      dump_valid <= prod_v && last;
      if (prod_v) begin
        if (cnt == '0) len_r <= len_eff;
        cnt <= last ? '0 : cnt + CNT_WIDTH'(1);
        acc_i_r <= last ? '0 : sum_i;
        acc_q_r <= last ? '0 : sum_q;
        if (last) begin
          acc_i <= sum_i;
          acc_q <= sum_q;
        end
      end
    end
endmodule

// File: tb/tb_carrier_wipeoff_acc.sv
// tb_carrier_wipeoff_acc: directed and randomized checks of carrier_wipeoff_acc
// against a sample-level model, with a 16-bit and an 8-bit accumulator instance.
module tb_carrier_wipeoff_acc;
  logic clk = 0, rst = 1, enable = 0, phase_load = 0, sample_valid = 0;
  logic [31:0] freq_word = 0, phase_init = 0;
  logic [15:0] dump_len = 1;
  logic [3:0] sample_sm = 0;
  logic signed [15:0] acc_i, acc_q;
  logic signed [7:0] a8_i, a8_q;
  logic dump_valid, dv8;
  logic [31:0] carrier_phase, phase8;
  int checks = 0, errors = 0;
  int tab[8] = '{7, 7, 6, 5, 4, 3, 2, 1};
  logic [31:0] m_phase;
  bit pend_v, e_dv;
  int pend_i, pend_q, cnt, len, s_i, s_q, s8_i, s8_q, e_i, e_q, e8_i, e8_q, ndump;

  always #5 clk = ~clk;

  carrier_wipeoff_acc dut (
    .clk(clk), .rst(rst), .enable(enable), .freq_word(freq_word), .phase_init(phase_init),
    .phase_load(phase_load), .dump_len(dump_len), .sample_valid(sample_valid), .sample_sm(sample_sm),
    .acc_i(acc_i), .acc_q(acc_q), .dump_valid(dump_valid), .carrier_phase(carrier_phase)
  );
  carrier_wipeoff_acc #(.ACC_WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .enable(enable), .freq_word(freq_word), .phase_init(phase_init),
    .phase_load(phase_load), .dump_len(dump_len), .sample_valid(sample_valid), .sample_sm(sample_sm),
    .acc_i(a8_i), .acc_q(a8_q), .dump_valid(dv8), .carrier_phase(phase8)
  );

  task automatic chk(string tag, longint act, longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic int acc_add(int a, int p, int w);
    int lo = -(1 << (w - 1));
    int hi = (1 << (w - 1)) - 1;
    int s = a + p;
`ifdef ACC_SATURATE_EN
    return s > hi ? hi : s < lo ? lo : s;
`else
    return ((s - lo) & ((1 << w) - 1)) + lo;
`endif
  endfunction

  // Complex product sample * e^{-j theta} using the 32-point carrier table.
  task automatic prod(input logic [31:0] ph, input logic [3:0] sm, output int pi, output int pq);
    int q = int'(ph[31:30]);
    int k = int'(ph[29:27]);
    int cm = (q % 2 == 0) ? tab[k] : tab[7 - k];
    int sn = (q % 2 == 0) ? tab[7 - k] : tab[k];
    int c = (q == 1 || q == 2) ? -cm : cm;
    int s = (q >= 2) ? -sn : sn;
    int si = (sm[3] ? -1 : 1) * (2 * int'(sm[2]) + 1);
    int sq = (sm[1] ? -1 : 1) * (2 * int'(sm[0]) + 1);
    pi = si * c + sq * s;
    pq = sq * c - si * s;
  endtask

  task automatic model_reset();
    m_phase = 0; pend_v = 0; e_dv = 0; cnt = 0; len = 1;
    s_i = 0; s_q = 0; s8_i = 0; s8_q = 0; e_i = 0; e_q = 0; e8_i = 0; e8_q = 0;
  endtask

  task automatic model_edge();
    e_dv = 0;
    if (!enable) begin
      pend_v = 0; cnt = 0; s_i = 0; s_q = 0; s8_i = 0; s8_q = 0;
    end else if (pend_v) begin
      if (cnt == 0) len = (dump_len == 0) ? 1 : int'(dump_len);
      s_i = acc_add(s_i, pend_i, 16); s_q = acc_add(s_q, pend_q, 16);
      s8_i = acc_add(s8_i, pend_i, 8); s8_q = acc_add(s8_q, pend_q, 8);
      cnt++;
      if (cnt == len) begin
        e_i = s_i; e_q = s_q; e8_i = s8_i; e8_q = s8_q; e_dv = 1;
        cnt = 0; s_i = 0; s_q = 0; s8_i = 0; s8_q = 0;
      end
    end
    pend_v = sample_valid && enable;
    if (pend_v) prod(m_phase, sample_sm, pend_i, pend_q);
    m_phase = phase_load ? phase_init : pend_v ? m_phase + freq_word : m_phase;
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("dump_valid", dump_valid, e_dv);
    chk("dump_valid8", dv8, e_dv);
    chk("acc_i", acc_i, e_i);
    chk("acc_q", acc_q, e_q);
    chk("acc8_i", a8_i, e8_i);
    chk("acc8_q", a8_q, e8_q);
    chk("phase", carrier_phase, m_phase);
    chk("phase8", phase8, m_phase);
    if (dump_valid) ndump++;
  endtask

  task automatic load_phase(input logic [31:0] p);
    phase_init = p; phase_load = 1;
    cycle();
    phase_load = 0;
  endtask

  task automatic run(input int n, input int idle);
    sample_valid = 1;
    repeat (n) cycle();
    sample_valid = 0;
    repeat (idle) cycle();
  endtask

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_acc_i", acc_i, 0);
    chk("rst_acc_q", acc_q, 0);
    chk("rst_dv", dump_valid, 0);
    chk("rst_phase", carrier_phase, 0);
    chk("rst_acc8_i", a8_i, 0);
    rst = 0;
    enable = 1;
    freq_word = 0; dump_len = 4; sample_sm = 4'b0100; ndump = 0;
    load_phase(32'h0);
    run(4, 3);
    chk("basic_i", acc_i, 88);
    chk("basic_q", acc_q, 16);
    chk("basic_dumps", ndump, 1);
    dump_len = 1;
    load_phase(32'h4000_0000);
    run(1, 3);
    chk("quad1_i", acc_i, 4);
    chk("quad1_q", acc_q, -22);
    load_phase(32'h0);
    freq_word = 32'h0800_0000; dump_len = 8;
    run(8, 0);
    chk("adv_phase", carrier_phase, 32'h4000_0000);
    repeat (3) cycle();
    chk("adv_i", acc_i, 140);
    chk("adv_q", acc_q, -70);
    freq_word = 0; dump_len = 2; ndump = 0;
    load_phase(32'h0);
    run(6, 3);
    chk("b2b_dumps", ndump, 3);
    dump_len = 4; ndump = 0;
    run(2, 0);
    enable = 0;
    cycle();
    enable = 1;
    run(4, 3);
    chk("flush_dumps", ndump, 1);
    chk("flush_i", acc_i, 88);
    dump_len = 8;
    run(8, 3);
    chk("sat16_i", acc_i, 176);
`ifdef ACC_SATURATE_EN
    chk("sat8_i", a8_i, 127);
`else
    chk("sat8_i", a8_i, -80);
`endif
    freq_word = 32'h0800_0000; dump_len = 4; ndump = 0;
    run(2, 0);
    rst = 1;
    #2;
    chk("arst_phase", carrier_phase, 0);
    chk("arst_acc_i", acc_i, 0);
    #1 rst = 0;
    model_reset();
    repeat (3) cycle();
    chk("arst_dumps", ndump, 0);
    for (int n = 0; n < 400; n++) begin
      enable = ($urandom_range(0, 19) != 0);
      sample_valid = ($urandom_range(0, 3) != 0);
      sample_sm = 4'($urandom);
      phase_load = ($urandom_range(0, 29) == 0);
      phase_init = $urandom;
      if ($urandom_range(0, 29) == 0) freq_word = $urandom;
      if ($urandom_range(0, 24) == 0) dump_len = 16'($urandom_range(0, 6));
      cycle();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
